// File: rtl/fm_pingpong_buf.sv
// fm_pingpong_buf: ping-pong feature-map buffer between the DMA mm2s stream
// and the PE array columns. One bank fills while the other is read; the banks
// swap under the tile_start/tile_done handshake.
// Optional feature macro: FM_PINGPONG_BUF_PARITY_EN (per-column even parity).
module fm_pingpong_buf #(
  parameter int unsigned COLS   = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS*DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   tile_rdy,
  output logic [AW:0]            tile_len,
  input  logic                   tile_start,
  input  logic                   tile_done,
  input  logic [COLS-1:0]        rd_en,
  input  logic [COLS*AW-1:0]     rd_addr,
  output logic [COLS*DATA_W-1:0] rd_data,
  output logic [COLS-1:0]        rd_valid,
  output logic                   ovf_err,
  output logic                   par_err,
  input  logic                   err_clr
);

  localparam int unsigned LEN_W = AW + 1;
`ifdef FM_PINGPONG_BUF_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_BUSY    = 2'd3
  } bank_state_t;

  bank_state_t            bank_q [2];
  bank_state_t            bank_d [2];
  logic [LEN_W-1:0]       len_q  [2];
  logic [LEN_W-1:0]       len_d  [2];
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic                   ovf_d;
  logic                   tready_d;
  logic                   tile_rdy_d;
  logic [LEN_W-1:0]       tile_len_d;
  logic                   wr_fire;
  logic                   rd_busy;
  logic [COLS-1:0]        rd_fire;
  logic [MEM_W-1:0]       rd_word [COLS];

  // Storage: [bank][column][address]; contents are never reset
  logic [MEM_W-1:0]       mem [2][COLS][DEPTH];

  assign wr_fire = s_axis_tvalid && s_axis_tready;
  assign rd_busy = (bank_q[rd_sel_q] == B_BUSY);

  // Bank state, pointers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]     <= B_EMPTY;
      bank_q[1]     <= B_EMPTY;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      wr_ptr_q      <= '0;
      ovf_err       <= 1'b0;
      s_axis_tready <= 1'b1;
      tile_rdy      <= 1'b0;
      tile_len      <= '0;
    end else begin
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      len_q[0]      <= len_d[0];
      len_q[1]      <= len_d[1];
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      wr_ptr_q      <= wr_ptr_d;
      ovf_err       <= ovf_d;
      s_axis_tready <= tready_d;
      tile_rdy      <= tile_rdy_d;
      tile_len      <= tile_len_d;
    end
  end

  // Next-state: write-side fill/close and read-side start/done act independently
  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    len_d[0]   = len_q[0];
    len_d[1]   = len_q[1];
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_err;
    tready_d   = 1'b0;
    tile_rdy_d = 1'b0;
    tile_len_d = '0;

    if (wr_fire) begin
      if (s_axis_tlast || (wr_ptr_q == AW'(DEPTH - 1))) begin
        bank_d[wr_sel_q] = B_FULL;
        len_d[wr_sel_q]  = LEN_W'(wr_ptr_q) + LEN_W'(1);
        wr_ptr_d         = '0;
        wr_sel_d         = ~wr_sel_q;
        // Truncated packet: remaining beats spill into the other bank
        if (!s_axis_tlast) ovf_d = 1'b1;
      end else begin
        bank_d[wr_sel_q] = B_FILLING;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
    end

    if (tile_start && (bank_q[rd_sel_q] == B_FULL)) begin
      bank_d[rd_sel_q] = B_BUSY;
    end

    if (tile_done && (bank_q[rd_sel_q] == B_BUSY)) begin
      bank_d[rd_sel_q] = B_EMPTY;
      rd_sel_d         = ~rd_sel_q;
    end

    // Clear wins over a same-cycle overflow
    if (err_clr) ovf_d = 1'b0;

    tready_d   = (bank_d[wr_sel_d] == B_EMPTY) || (bank_d[wr_sel_d] == B_FILLING);
    tile_rdy_d = (bank_d[rd_sel_d] == B_FULL);
    tile_len_d = len_d[rd_sel_d];
  end

  // Write all column lanes of an accepted beat at the fill pointer
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned c = 0; c < COLS; c++) begin
`ifdef FM_PINGPONG_BUF_PARITY_EN
        mem[wr_sel_q][c][wr_ptr_q] <= {^s_axis_tdata[c*DATA_W +: DATA_W],
                                       s_axis_tdata[c*DATA_W +: DATA_W]};
`else
        mem[wr_sel_q][c][wr_ptr_q] <= s_axis_tdata[c*DATA_W +: DATA_W];
`endif
      end
    end
  end

  // Per-column read word and service qualifier
  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      rd_word[c] = mem[rd_sel_q][c][rd_addr[c*AW +: AW]];
      rd_fire[c] = rd_en[c] && rd_busy;
    end
  end

  // Registered read data: zero for columns not serviced this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int unsigned c = 0; c < COLS; c++) begin
        rd_valid[c]                  <= rd_fire[c];
        rd_data[c*DATA_W +: DATA_W]  <= rd_fire[c] ? rd_word[c][DATA_W-1:0] : '0;
      end
    end
  end

`ifdef FM_PINGPONG_BUF_PARITY_EN
  logic [COLS-1:0] par_bad;

  // Even-parity check on every serviced read
  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      par_bad[c] = rd_fire[c] && (^rd_word[c]);
    end
  end

  // Sticky parity error, raised alongside rd_valid; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            par_err <= 1'b0;
    else if (err_clr)   par_err <= 1'b0;
    else if (|par_bad)  par_err <= 1'b1;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_fm_pingpong_buf.sv
// Directed bench for fm_pingpong_buf (COLS=8, DATA_W=8, DEPTH=16).
module tb_fm_pingpong_buf;

  localparam int unsigned COLS   = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned BW     = COLS * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [BW-1:0]     s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              tile_rdy;
  logic [AW:0]       tile_len;
  logic              tile_start;
  logic              tile_done;
  logic [COLS-1:0]   rd_en;
  logic [COLS*AW-1:0] rd_addr;
  logic [BW-1:0]     rd_data;
  logic [COLS-1:0]   rd_valid;
  logic              ovf_err;
  logic              par_err;
  logic              err_clr;

  int n_chk  = 0;
  int n_pass = 0;

  fm_pingpong_buf #(.COLS(COLS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .tile_rdy(tile_rdy), .tile_len(tile_len),
    .tile_start(tile_start), .tile_done(tile_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ovf_err(ovf_err), .par_err(par_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Beat b (0-based) of tile t: distinct byte per column
  function automatic logic [BW-1:0] beat_word(input int t, input int b);
    logic [BW-1:0] w;
    for (int c = 0; c < COLS; c++) w[c*DATA_W +: DATA_W] = DATA_W'(t*64 + b*3 + c*17);
    return w;
  endfunction

  // Stream n_send beats of an n_total-beat packet; reports any back-pressure
  task automatic send_beats(input int t, input int n_total, input int n_send, output bit stalled);
    int budget;
    stalled = 1'b0;
    for (int b = 0; b < n_send; b++) begin
      s_axis_tdata  = beat_word(t, b);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == n_total - 1);
      budget = 0;
      while (!s_axis_tready && budget < 50) begin
        stalled = 1'b1;
        @(negedge clk);
        budget++;
      end
      if (!s_axis_tready) begin
        chk("tready_wait", 64'(s_axis_tready), 64'd1);
        break;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pulse_start();
    tile_start = 1'b1; @(negedge clk); tile_start = 1'b0;
  endtask

  task automatic pulse_done();
    tile_done = 1'b1; @(negedge clk); tile_done = 1'b0;
  endtask

  // One-cycle read of all columns at address a
  task automatic read_all(input int a);
    rd_en = '1;
    for (int c = 0; c < COLS; c++) rd_addr[c*AW +: AW] = AW'(a);
    @(negedge clk);
    rd_en = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"},   64'(s_axis_tready), 64'd1);
    chk({tag, "_tile_rdy"}, 64'(tile_rdy),      64'd0);
    chk({tag, "_tile_len"}, 64'(tile_len),      64'd0);
    chk({tag, "_rd_data"},  64'(rd_data),       64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid),      64'd0);
    chk({tag, "_ovf"},      64'(ovf_err),       64'd0);
    chk({tag, "_par"},      64'(par_err),       64'd0);
  endtask

  initial begin
    bit stalled;
    logic [BW-1:0] exp_w;

    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tile_start = 1'b0; tile_done = 1'b0; rd_en = '0; rd_addr = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic 5-beat tile into bank 0
    send_beats(0, 5, 5, stalled);
    chk("t0_rdy", 64'(tile_rdy), 64'd1);
    chk("t0_len", 64'(tile_len), 64'd5);
    chk("t0_tready", 64'(s_axis_tready), 64'd1);

    // tile_start with a same-cycle read: read is not serviced
    tile_start = 1'b1; rd_en = '1; rd_addr = '0;
    @(negedge clk);
    tile_start = 1'b0; rd_en = '0;
    chk("start_rd_same_cycle", 64'(rd_valid), 64'd0);
    chk("t0_rdy_after_start", 64'(tile_rdy), 64'd0);
    for (int a = 0; a < 5; a++) begin
      read_all(a);
      chk($sformatf("t0_valid_a%0d", a), 64'(rd_valid), 64'hff);
      chk($sformatf("t0_data_a%0d", a), rd_data, beat_word(0, a));
    end

    // Ping-pong: fill bank 1 while bank 0 is busy
    send_beats(1, 16, 16, stalled);
    chk("pp_no_stall", 64'(stalled), 64'd0);
    chk("pp_tready_blocked", 64'(s_axis_tready), 64'd0);
    chk("pp_rdy_while_busy", 64'(tile_rdy), 64'd0);
    pulse_done();
    chk("pp_rdy_after_done", 64'(tile_rdy), 64'd1);
    chk("pp_len_after_done", 64'(tile_len), 64'd16);
    chk("pp_tready_after_done", 64'(s_axis_tready), 64'd1);

    // tile_done while the read bank is only FULL: ignored
    pulse_done();
    chk("misuse_done_full_rdy", 64'(tile_rdy), 64'd1);
    chk("misuse_done_full_len", 64'(tile_len), 64'd16);

    // Per-column addresses on bank 1
    pulse_start();
    rd_en = '1;
    for (int c = 0; c < COLS; c++) rd_addr[c*AW +: AW] = AW'(15 - c);
    @(negedge clk);
    rd_en = '0;
    for (int c = 0; c < COLS; c++) begin
      logic [BW-1:0] bw;
      bw = beat_word(1, 15 - c);
      exp_w[c*DATA_W +: DATA_W] = bw[c*DATA_W +: DATA_W];
    end
    chk("pp_percol_data", rd_data, exp_w);
    pulse_done();
    chk("both_empty_rdy", 64'(tile_rdy), 64'd0);

    // Misuse: start with nothing ready, read with nothing busy, done with nothing busy
    pulse_start();
    read_all(0);
    chk("misuse_rd_not_busy_valid", 64'(rd_valid), 64'd0);
    chk("misuse_rd_not_busy_data", rd_data, 64'd0);
    pulse_done();
    chk("misuse_done_rdy", 64'(tile_rdy), 64'd0);
    chk("misuse_done_tready", 64'(s_axis_tready), 64'd1);

    // Overflow: 20-beat packet truncated at 16, tail spills to bank 1
    send_beats(2, 20, 20, stalled);
    chk("ovf_no_stall", 64'(stalled), 64'd0);
    chk("ovf_err_set", 64'(ovf_err), 64'd1);
    chk("ovf_rdy", 64'(tile_rdy), 64'd1);
    chk("ovf_len_b0", 64'(tile_len), 64'd16);
    pulse_start();
    read_all(3);
    chk("ovf_b0_data", rd_data, beat_word(2, 3));
    pulse_done();
    chk("ovf_rdy_b1", 64'(tile_rdy), 64'd1);
    chk("ovf_len_b1", 64'(tile_len), 64'd4);
    pulse_start();
    read_all(0);
    chk("ovf_b1_data", rd_data, beat_word(2, 16));
    pulse_done();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("ovf_err_clr", 64'(ovf_err), 64'd0);

    // Reset in the middle of an 8-beat fill
    send_beats(3, 8, 3, stalled);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    send_beats(4, 2, 2, stalled);
    chk("post_rst_rdy", 64'(tile_rdy), 64'd1);
    chk("post_rst_len", 64'(tile_len), 64'd2);
    pulse_start();
    read_all(1);
    chk("post_rst_data", rd_data, beat_word(4, 1));
    pulse_done();

`ifdef FM_PINGPONG_BUF_PARITY_EN
    // Corrupt bank 1, column 3, address 2 and read it back
    send_beats(5, 3, 3, stalled);
    chk("par_rdy", 64'(tile_rdy), 64'd1);
    pulse_start();
    dut.mem[1][3][2] = dut.mem[1][3][2] ^ 9'd1;
    chk("par_before", 64'(par_err), 64'd0);
    read_all(2);
    chk("par_err_set", 64'(par_err), 64'd1);
    exp_w = beat_word(5, 2);
    exp_w[3*DATA_W +: DATA_W] = exp_w[3*DATA_W +: DATA_W] ^ 8'd1;
    chk("par_data", rd_data, exp_w);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("par_err_clr", 64'(par_err), 64'd0);
    pulse_done();
`else
    chk("par_tied_zero", 64'(par_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
